bit_word_emitter: RTL and testbench

BIT_WORD_EMITTER -- requirements
Module: bit_word_emitter

---
 rtl/bit_word_emitter_if.sv | 43 ++++
 rtl/bit_word_emitter.sv | 125 ++++++++++++
 tb/tb_bit_word_emitter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/bit_word_emitter_if.sv
// Chunk-in / word-out stream bundle for the bit packer.
// master drives chunks and out_ready; slave is the packer.
interface bit_word_emitter_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [6:0]  in_len;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [3:0]  out_bytes;
    logic        out_last;
    logic [31:0] total_bytes;

    modport master (
        output in_valid,
        input  in_ready,
        output in_data,
        output in_len,
        output in_last,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_bytes,
        input  out_last,
        input  total_bytes
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_data,
        input  in_len,
        input  in_last,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_bytes,
        output out_last,
        output total_bytes
    );
endinterface

// File: rtl/bit_word_emitter.sv
// Packs variable-length LSB-first code chunks into 64-bit words,
// flushing a final partial word when the stream ends.
module bit_word_emitter (
    input  logic                 clk,
    input  logic                 reset_n,
    bit_word_emitter_if.slave    bus
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [127:0] acc_q, acc_d;
    logic [7:0]   fill_q, fill_d;
    logic [31:0]  total_q, total_d;

    logic [6:0]   len;
    logic [63:0]  mask;
    logic [63:0]  chunk;
    logic [127:0] chunk_w;
    logic [7:0]   ceil8;
    logic         fill_ge64;
    logic         out_valid;
    logic         out_last;
    logic [3:0]   out_bytes;
    logic         in_ready;
    logic         fire_in;
    logic         fire_out;

    // Saturate the length, then clear every bit above it
    always_comb begin
        len   = (bus.in_len > 7'd64) ? 7'd64 : bus.in_len;
        mask  = (len == 7'd64) ? '1 : ((64'd1 << len) - 64'd1);
        chunk = bus.in_data & mask;
        chunk_w = {64'd0, chunk};
    end

    assign fill_ge64 = (fill_q >= 8'd64);
    assign ceil8     = (fill_q + 8'd7) >> 3;

    always_comb begin
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_bytes = 4'd8;
        in_ready  = 1'b0;
        unique case (state_q)
            RUN: begin
                out_valid = fill_ge64;
                in_ready  = !fill_ge64 || bus.out_ready;
            end
            FLUSH: begin
                out_valid = 1'b1;
                out_last  = (fill_q <= 8'd64);
                out_bytes = fill_ge64 ? 4'd8 : ceil8[3:0];
            end
            default: ;
        endcase
    end

    assign fire_in  = bus.in_valid && in_ready;
    assign fire_out = out_valid && bus.out_ready;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        fill_d  = fill_q;
        total_d = total_q;
        if (fire_out)
            total_d = total_q + {28'd0, out_bytes};
        unique case (state_q)
            RUN: begin
                if (fire_in && fire_out) begin
                    acc_d  = (acc_q >> 64)
                           | (chunk_w << (fill_q - 8'd64));
                    fill_d = fill_q - 8'd64 + {1'b0, len};
                end else if (fire_in) begin
                    acc_d  = acc_q | (chunk_w << fill_q);
                    fill_d = fill_q + {1'b0, len};
                end else if (fire_out) begin
                    acc_d  = acc_q >> 64;
                    fill_d = fill_q - 8'd64;
                end
                if (fire_in && bus.in_last)
                    state_d = FLUSH;
            end
            FLUSH: begin
                if (fire_out) begin
                    if (out_last) begin
                        acc_d   = '0;
                        fill_d  = '0;
                        state_d = RUN;
                    end else begin
                        acc_d  = acc_q >> 64;
                        fill_d = fill_q - 8'd64;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
            acc_q   <= '0;
            fill_q  <= '0;
            total_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            fill_q  <= fill_d;
            total_q <= total_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.out_data    = acc_q[63:0];
    assign bus.out_bytes   = out_bytes;
    assign bus.out_last    = out_last;
    assign bus.total_bytes = total_q;

endmodule

// File: tb/tb_bit_word_emitter.sv
// Directed bench for bit_word_emitter: packing, flush, streaming,
// backpressure, empty stream, length saturation and reset.
module tb_bit_word_emitter;

    logic clk = 1'b0;
    logic reset_n;
    int   vectors = 0;
    int   miscompares = 0;

    bit_word_emitter_if bus ();

    bit_word_emitter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one chunk and hold it until accepted (bounded wait)
    task automatic send(input logic [63:0] d,
                        input logic [6:0] l,
                        input logic last);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_len   = l;
        bus.in_last  = last;
        #1;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        chk("send_wait", {63'd0, n < 20}, 64'd1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        #1;
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_len    = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        #2;
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("rst_total", {32'd0, bus.total_bytes}, 64'd0);
        chk("rst_out_data", bus.out_data, 64'd0);
        tick();
        reset_n = 1'b1;

        // Pack test
        send(64'h5, 7'd3, 1'b0);
        send(64'h1F, 7'd5, 1'b0);
        for (int i = 0; i < 7; i++)
            send(64'hFF, 7'd8, 1'b0);
        chk("pack_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("pack_data", bus.out_data, 64'hFFFF_FFFF_FFFF_FFFD);
        chk("pack_bytes", {60'd0, bus.out_bytes}, 64'd8);
        chk("pack_last", {63'd0, bus.out_last}, 64'd0);
        chk("pack_in_ready", {63'd0, bus.in_ready}, 64'd0);
        handshake();
        chk("pack_after_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("pack_after_fill", {56'd0, dut.fill_q}, 64'd0);
        chk("pack_total", {32'd0, bus.total_bytes}, 64'd8);

        // Flush test
        send(64'hABC, 7'd12, 1'b1);
        chk("flush_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("flush_data", bus.out_data, 64'hABC);
        chk("flush_bytes", {60'd0, bus.out_bytes}, 64'd2);
        chk("flush_last", {63'd0, bus.out_last}, 64'd1);
        chk("flush_in_ready", {63'd0, bus.in_ready}, 64'd0);
        handshake();
        chk("flush_done_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("flush_run_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("flush_total", {32'd0, bus.total_bytes}, 64'd10);

        // Backpressure at fill = 100, then exact-boundary flush
        send(64'hFFFF_FFF9_8765_4321, 7'd36, 1'b0);
        send(64'h0123_4567_89AB_CDEF, 7'd64, 1'b0);
        chk("bp_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
        chk("bp_data", bus.out_data, 64'h9ABC_DEF9_8765_4321);
        bus.in_valid = 1'b1;
        bus.in_data  = 64'h1234_5678_9ABC_DEF1;
        bus.in_len   = 7'd28;
        bus.in_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_stable", bus.out_data, 64'h9ABC_DEF9_8765_4321);
            chk("bp_blocked", {63'd0, bus.in_ready}, 64'd0);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_ready_pass", {63'd0, bus.in_ready}, 64'd1);
        chk("bp_w0_last", {63'd0, bus.out_last}, 64'd0);
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        chk("bp_w1_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("bp_w1_data", bus.out_data, 64'hABCD_EF10_1234_5678);
        chk("bp_w1_bytes", {60'd0, bus.out_bytes}, 64'd8);
        chk("bp_w1_last", {63'd0, bus.out_last}, 64'd1);
        chk("bp_total1", {32'd0, bus.total_bytes}, 64'd18);
        handshake();
        chk("bp_done_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("bp_total2", {32'd0, bus.total_bytes}, 64'd26);

        // Two-word flush with a partial tail
        send(64'hFFFF_FF11_2233_4455, 7'd40, 1'b0);
        send(64'h0000_0066_7788_99AA, 7'd40, 1'b1);
        chk("fl2_w0_data", bus.out_data, 64'h8899_AA11_2233_4455);
        chk("fl2_w0_bytes", {60'd0, bus.out_bytes}, 64'd8);
        chk("fl2_w0_last", {63'd0, bus.out_last}, 64'd0);
        handshake();
        chk("fl2_w1_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("fl2_w1_data", bus.out_data, 64'h6677);
        chk("fl2_w1_bytes", {60'd0, bus.out_bytes}, 64'd2);
        chk("fl2_w1_last", {63'd0, bus.out_last}, 64'd1);
        handshake();
        chk("fl2_done", {63'd0, bus.out_valid}, 64'd0);
        chk("fl2_total", {32'd0, bus.total_bytes}, 64'd36);

        // Empty stream
        send(64'hFFFF, 7'd0, 1'b1);
        chk("empty_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("empty_data", bus.out_data, 64'd0);
        chk("empty_bytes", {60'd0, bus.out_bytes}, 64'd0);
        chk("empty_last", {63'd0, bus.out_last}, 64'd1);
        handshake();
        chk("empty_total", {32'd0, bus.total_bytes}, 64'd36);

        // Zero-length chunk without last is a no-op
        send(64'hFFFF, 7'd0, 1'b0);
        chk("len0_fill", {56'd0, dut.fill_q}, 64'd0);
        chk("len0_valid", {63'd0, bus.out_valid}, 64'd0);

        // Length saturation
        send('1, 7'd100, 1'b1);
        chk("sat_data", bus.out_data, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("sat_bytes", {60'd0, bus.out_bytes}, 64'd8);
        chk("sat_last", {63'd0, bus.out_last}, 64'd1);
        handshake();
        chk("sat_total", {32'd0, bus.total_bytes}, 64'd44);

        // Streaming: one word per cycle after the first fill
        bus.in_valid  = 1'b1;
        bus.in_data   = '1;
        bus.in_len    = 7'd64;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("stream_in_ready", {63'd0, bus.in_ready}, 64'd1);
            tick();
            chk("stream_valid", {63'd0, bus.out_valid}, 64'd1);
        end
        bus.in_valid = 1'b0;
        tick();
        bus.out_ready = 1'b0;
        #1;
        chk("stream_drain", {63'd0, bus.out_valid}, 64'd0);
        chk("stream_total", {32'd0, bus.total_bytes}, 64'd92);

        // Reset mid-stream with fill = 70
        send(64'h3F, 7'd6, 1'b0);
        send('1, 7'd64, 1'b0);
        chk("prerst_valid", {63'd0, bus.out_valid}, 64'd1);
        reset_n = 1'b0;
        #1;
        chk("rst2_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst2_total", {32'd0, bus.total_bytes}, 64'd0);
        chk("rst2_in_ready", {63'd0, bus.in_ready}, 64'd1);
        tick();
        reset_n = 1'b1;
        send(64'h5, 7'd3, 1'b1);
        chk("postrst_data", bus.out_data, 64'h5);
        chk("postrst_bytes", {60'd0, bus.out_bytes}, 64'd1);
        chk("postrst_last", {63'd0, bus.out_last}, 64'd1);
        handshake();
        chk("postrst_total", {32'd0, bus.total_bytes}, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
